// File: rtl/pipeline_mem_lsu_if.sv
// Data-memory bus between the MEM-stage LSU (master) and data memory (slave).
// Request side: req/gnt handshake carrying a word-aligned address, byte enables,
// write flag and lane-replicated write data. Response side: rvalid + rdata for loads.
interface pipeline_mem_lsu_if;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/pipeline_mem_lsu.sv
// MEM-stage load/store unit.
// Takes EX/MEM fields, runs loads/stores over the req/gnt + rvalid memory bus,
// aligns and extends load data, stalls upstream while an access is in flight and
// presents registered MEM/WB fields with a one-cycle valid pulse per retirement.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned h/w accesses retire
// immediately with misalign_out=1 instead of touching memory).
module pipeline_mem_lsu #(
    parameter logic [6:0] LOAD_OPC  = 7'b0000011,
    parameter logic [6:0] STORE_OPC = 7'b0100011
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    input  logic [31:0]        result_in,
    input  logic [31:0]        data_in,
    input  logic [4:0]         rd_in,
    input  logic [6:0]         opcode_in,
    input  logic [2:0]         funct3_in,
    output logic               stall_out,
    pipeline_mem_lsu_if.master mem,
    output logic               valid_out,
    output logic [31:0]        result_out,
    output logic [4:0]         rd_out,
    output logic [6:0]         opcode_out,
    output logic               misalign_out
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t      state_q, state_d;

    logic        is_load, is_store, is_mem, trap;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;

    // Request fields, captured on acceptance
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] ea_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic [6:0]  opc_q;

    // MEM/WB output register
    logic        vout_q;
    logic [31:0] res_q;
    logic [4:0]  rdo_q;
    logic [6:0]  opo_q;
    logic        mis_q;

    logic        capture, retire, ret_mis;
    logic [31:0] ret_res;
    logic [4:0]  ret_rd;
    logic [6:0]  ret_opc;

    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] load_val;

    assign is_load  = (opcode_in == LOAD_OPC);
    assign is_store = (opcode_in == STORE_OPC);
    assign is_mem   = is_load | is_store;

    // Size comes from funct3[1:0]: bu/hu share the b/h lanes, reserved codes behave as word
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = data_in;
        case (funct3_in[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << result_in[1:0];
                wdata_calc = {4{data_in[7:0]}};
            end
            2'b01: begin
                be_calc    = result_in[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{data_in[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Halfwords need a[0]=0; words (and reserved sizes) need a[1:0]=0
    always_comb begin
        case (funct3_in[1:0])
            2'b00:   trap = 1'b0;
            2'b01:   trap = result_in[0];
            default: trap = |result_in[1:0];
        endcase
    end
`else
    assign trap = 1'b0;
`endif

    // Select the addressed lane of the returned word and extend per funct3
    always_comb begin
        case (ea_q[1:0])
            2'b00:   rbyte = mem.mem_rdata[7:0];
            2'b01:   rbyte = mem.mem_rdata[15:8];
            2'b10:   rbyte = mem.mem_rdata[23:16];
            default: rbyte = mem.mem_rdata[31:24];
        endcase
        rhalf = ea_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_val = {{24{rbyte[7]}}, rbyte};
            3'b001:  load_val = {{16{rhalf[15]}}, rhalf};
            3'b100:  load_val = {24'd0, rbyte};
            3'b101:  load_val = {16'd0, rhalf};
            default: load_val = mem.mem_rdata;
        endcase
    end

    // Next-state, request, stall and retire decode; stall drops in the completing cycle
    always_comb begin
        state_d      = state_q;
        stall_out    = 1'b0;
        mem.mem_req  = 1'b0;
        capture      = 1'b0;
        retire       = 1'b0;
        ret_res      = ea_q;
        ret_rd       = rd_q;
        ret_opc      = opc_q;
        ret_mis      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    if (is_mem && trap) begin
                        retire  = 1'b1;
                        ret_res = result_in;
                        ret_rd  = '0;
                        ret_opc = opcode_in;
                        ret_mis = 1'b1;
                    end else if (is_mem) begin
                        capture   = 1'b1;
                        stall_out = 1'b1;
                        state_d   = S_REQ;
                    end else begin
                        retire  = 1'b1;
                        ret_res = result_in;
                        ret_rd  = rd_in;
                        ret_opc = opcode_in;
                    end
                end
            end
            S_REQ: begin
                mem.mem_req = 1'b1;
                if (mem.mem_gnt && we_q) begin
                    retire  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    stall_out = 1'b1;
                    if (mem.mem_gnt) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem.mem_rvalid) begin
                    retire  = 1'b1;
                    ret_res = load_val;
                    state_d = S_IDLE;
                end else begin
                    stall_out = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register; async reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Request fields latched on acceptance and held stable through REQ/WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            ea_q    <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            opc_q   <= '0;
        end else if (capture) begin
            we_q    <= is_store;
            addr_q  <= {result_in[31:2], 2'b00};
            be_q    <= be_calc;
            wdata_q <= wdata_calc;
            ea_q    <= result_in;
            f3_q    <= funct3_in;
            rd_q    <= rd_in;
            opc_q   <= opcode_in;
        end
    end

    // MEM/WB register: valid pulses on retire, payload holds between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vout_q <= 1'b0;
            res_q  <= '0;
            rdo_q  <= '0;
            opo_q  <= '0;
            mis_q  <= 1'b0;
        end else begin
            vout_q <= retire;
            if (retire) begin
                res_q <= ret_res;
                rdo_q <= ret_rd;
                opo_q <= ret_opc;
                mis_q <= ret_mis;
            end
        end
    end

    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

    assign valid_out    = vout_q;
    assign result_out   = res_q;
    assign rd_out       = rdo_q;
    assign opcode_out   = opo_q;
    assign misalign_out = mis_q;

endmodule

// File: tb/tb_pipeline_mem_lsu.sv
// Self-checking bench for pipeline_mem_lsu: reset values, a directed vector
// table, hand-written reset/back-to-back sequences, and randomized ops checked
// against a byte-addressed memory model.
module tb_pipeline_mem_lsu;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_ALU   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] result_in, data_in;
    logic [4:0]  rd_in;
    logic [6:0]  opcode_in;
    logic [2:0]  funct3_in;
    logic        stall_out, valid_out, misalign_out;
    logic [31:0] result_out;
    logic [4:0]  rd_out;
    logic [6:0]  opcode_out;

    int checks   = 0;
    int failures = 0;

    logic [31:0] dut_mem [8];
    logic [7:0]  ref_mem [32];

    always #5 clk = ~clk;

    pipeline_mem_lsu_if bus ();

    pipeline_mem_lsu #(
        .LOAD_OPC (7'b0000011),
        .STORE_OPC(7'b0100011)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .result_in   (result_in),
        .data_in     (data_in),
        .rd_in       (rd_in),
        .opcode_in   (opcode_in),
        .funct3_in   (funct3_in),
        .stall_out   (stall_out),
        .mem         (bus),
        .valid_out   (valid_out),
        .result_out  (result_out),
        .rd_out      (rd_out),
        .opcode_out  (opcode_out),
        .misalign_out(misalign_out)
    );

    typedef struct {
        int          lat;
        int          stalls;
        logic        req_seen;
        logic        stable;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] res;
        logic [4:0]  rd;
        logic [6:0]  opc;
        logic        mis;
    } obs_t;

    typedef struct {
        string       nm;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          gd;
        int          rv;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] res;
        int          lat;
        int          stalls;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [6:0] opc, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                                input logic [31:0] rdata, input int gd, input int rv,
                                input logic [3:0] be, input logic [31:0] wdata,
                                input logic [31:0] res, input int lat, input int stalls);
        vec_t v;
        v.nm = nm; v.opc = opc; v.f3 = f3; v.a = a; v.d = d; v.rd = rd; v.rdata = rdata;
        v.gd = gd; v.rv = rv; v.be = be; v.wdata = wdata; v.res = res; v.lat = lat; v.stalls = stalls;
        return v;
    endfunction

    // Present one instruction at posedge+1 and play memory until it retires.
    // gd = REQ cycles without grant, rv = cycles from grant to rvalid (>=1).
    // Stray rvalid is driven whenever the DUT is not waiting, and must be ignored.
    task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [4:0] rd, input int gd, input int rv,
                          output obs_t o);
        int   cyc, req_n, gnt_cyc;
        logic granted, done, adv;
        o.lat = -1; o.stalls = 0; o.req_seen = 1'b0; o.stable = 1'b1; o.addr = '0; o.be = '0;
        o.we = 1'b0; o.wdata = '0; o.res = '0; o.rd = '0; o.opc = '0; o.mis = 1'b0;
        valid_in = 1'b1; opcode_in = opc; funct3_in = f3; result_in = a; data_in = d; rd_in = rd;
        cyc = 0; req_n = 0; gnt_cyc = 0; granted = 1'b0; done = 1'b0;
        while (!done) begin
            if (cyc > 0 && valid_out === 1'b1) begin
                done = 1'b1;
                o.lat = cyc; o.res = result_out; o.rd = rd_out; o.opc = opcode_out; o.mis = misalign_out;
            end else if (cyc > 40) begin
                done = 1'b1;
                checks++; failures++;
                $display("FAIL retire_timeout: got no valid_out expected retire within 40 cycles");
            end else begin
                bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'hBAD0_BAD0;
                if (bus.mem_req === 1'b1) begin
                    if (!o.req_seen) begin
                        o.req_seen = 1'b1; o.addr = bus.mem_addr; o.be = bus.mem_be;
                        o.we = bus.mem_we; o.wdata = bus.mem_wdata;
                    end else if (bus.mem_addr !== o.addr || bus.mem_be !== o.be ||
                                 bus.mem_we !== o.we || bus.mem_wdata !== o.wdata) begin
                        o.stable = 1'b0;
                    end
                    if (req_n == gd) begin
                        bus.mem_gnt = 1'b1; granted = 1'b1; gnt_cyc = cyc;
                        if (bus.mem_we)
                            for (int i = 0; i < 4; i++)
                                if (bus.mem_be[i]) dut_mem[bus.mem_addr[4:2]][8*i +: 8] = bus.mem_wdata[8*i +: 8];
                    end else begin
                        bus.mem_rvalid = 1'b1;
                    end
                    req_n++;
                end else if (granted) begin
                    if (cyc == gnt_cyc + rv) begin
                        bus.mem_rvalid = 1'b1; bus.mem_rdata = dut_mem[o.addr[4:2]];
                    end
                end else begin
                    bus.mem_rvalid = 1'b1;
                end
                #1;
                if (stall_out === 1'b1) o.stalls++;
                adv = (stall_out !== 1'b1);
                @(posedge clk); #1;
                if (adv) valid_in = 1'b0;
                cyc++;
            end
        end
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        valid_in = 1'b0;
    endtask

    // One empty cycle: valid_out must fall and the payload must hold
    task automatic idle_check(input logic [31:0] res, input logic [4:0] rd, input logic [6:0] opc);
        valid_in = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        @(posedge clk); #1;
        chk("pulse_low", 32'(valid_out), 32'd0);
        chk("hold_result", result_out, res);
        chk("hold_rd", 32'(rd_out), 32'(rd));
        chk("hold_opcode", 32'(opcode_out), 32'(opc));
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int          sz, base;
        logic [31:0] v;
        sz   = size_of(f3);
        base = int'(a % 32'd32);
        base = base - (base % sz);
        v    = '0;
        for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
        if ((f3 == 3'b000 || f3 == 3'b001) && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int sz, base;
        sz   = size_of(f3);
        base = int'(a % 32'd32);
        base = base - (base % sz);
        for (int i = 0; i < sz; i++) ref_mem[base + i] = 8'(d >> (8 * i));
    endtask

    initial begin
        vec_t        tbl[$];
        vec_t        v;
        obs_t        o;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] a, d, exp_res;
        logic [4:0]  rd, exp_rd;
        int          kind, gd, rv, exp_lat;
        logic        is_mis;

        rst_n = 1'b0; valid_in = 1'b0; result_in = '0; data_in = '0; rd_in = '0;
        opcode_in = '0; funct3_in = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        for (int i = 0; i < 8; i++) dut_mem[i] = 32'h0101_0101 * (i + 1);

        // Reset values
        #3;
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_result_out", result_out, 32'd0);
        chk("rst_rd_out", 32'(rd_out), 32'd0);
        chk("rst_opcode_out", 32'(opcode_out), 32'd0);
        chk("rst_misalign_out", 32'(misalign_out), 32'd0);
        chk("rst_stall_out", 32'(stall_out), 32'd0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        tbl.push_back(mk("alu",   OPC_ALU,   3'b000, 32'h0000_1234, 32'h0,         5'd5,  32'h0,         0, 1, 4'h0,    32'h0,         32'h0000_1234, 1, 0));
        tbl.push_back(mk("sw",    OPC_STORE, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0,  32'h0,         1, 1, 4'hF,    32'hDEAD_BEEF, 32'h0000_0100, 3, 2));
        tbl.push_back(mk("lb",    OPC_LOAD,  3'b000, 32'h0000_0203, 32'h0,         5'd9,  32'h80FF_0000, 0, 2, 4'b1000, 32'h0,         32'hFFFF_FF80, 4, 3));
        tbl.push_back(mk("lhu",   OPC_LOAD,  3'b101, 32'h0000_0202, 32'h0,         5'd10, 32'h8001_0000, 0, 1, 4'b1100, 32'h0,         32'h0000_8001, 3, 2));
        tbl.push_back(mk("lh",    OPC_LOAD,  3'b001, 32'h0000_0202, 32'h0,         5'd11, 32'h8001_0000, 1, 1, 4'b1100, 32'h0,         32'hFFFF_8001, 4, 3));
        tbl.push_back(mk("sb",    OPC_STORE, 3'b000, 32'h0000_0101, 32'h1234_56A5, 5'd0,  32'h0,         0, 1, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0101, 2, 1));
        tbl.push_back(mk("sh",    OPC_STORE, 3'b001, 32'h0000_0106, 32'hFFFF_BEEF, 5'd0,  32'h0,         2, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0106, 4, 3));
        tbl.push_back(mk("lbu",   OPC_LOAD,  3'b100, 32'h0000_0105, 32'h0,         5'd12, 32'h1234_8F00, 0, 3, 4'b0010, 32'h0,         32'h0000_008F, 5, 4));
        tbl.push_back(mk("lw",    OPC_LOAD,  3'b010, 32'h0000_0108, 32'h0,         5'd13, 32'hCAFE_F00D, 1, 2, 4'hF,    32'h0,         32'hCAFE_F00D, 5, 4));
        tbl.push_back(mk("l_f3_3",OPC_LOAD,  3'b011, 32'h0000_010C, 32'h0,         5'd14, 32'h1122_3344, 0, 1, 4'hF,    32'h0,         32'h1122_3344, 3, 2));
`ifndef MEM_MISALIGN_TRAP_EN
        tbl.push_back(mk("lw_a2", OPC_LOAD,  3'b010, 32'h0000_010E, 32'h0,         5'd15, 32'hA0B0_C0D0, 0, 1, 4'hF,    32'h0,         32'hA0B0_C0D0, 3, 2));
        tbl.push_back(mk("lh_a1", OPC_LOAD,  3'b001, 32'h0000_0103, 32'h0,         5'd16, 32'h8765_4321, 0, 1, 4'b1100, 32'h0,         32'hFFFF_8765, 3, 2));
`endif
        foreach (tbl[i]) begin
            v = tbl[i];
            if (v.opc == OPC_LOAD) dut_mem[v.a[4:2]] = v.rdata;
            run_op(v.opc, v.f3, v.a, v.d, v.rd, v.gd, v.rv, o);
            chk({v.nm, "_lat"}, 32'(o.lat), 32'(v.lat));
            chk({v.nm, "_stalls"}, 32'(o.stalls), 32'(v.stalls));
            chk({v.nm, "_result"}, o.res, v.res);
            chk({v.nm, "_rd"}, 32'(o.rd), 32'(v.rd));
            chk({v.nm, "_opcode"}, 32'(o.opc), 32'(v.opc));
            chk({v.nm, "_misalign"}, 32'(o.mis), 32'd0);
            chk({v.nm, "_req_seen"}, 32'(o.req_seen), 32'(v.opc != OPC_ALU));
            if (v.opc != OPC_ALU) begin
                chk({v.nm, "_addr"}, o.addr, {v.a[31:2], 2'b00});
                chk({v.nm, "_be"}, 32'(o.be), 32'(v.be));
                chk({v.nm, "_we"}, 32'(o.we), 32'(v.opc == OPC_STORE));
                chk({v.nm, "_stable"}, 32'(o.stable), 32'd1);
                if (v.opc == OPC_STORE) chk({v.nm, "_wdata"}, o.wdata, v.wdata);
            end
            idle_check(v.res, v.rd, v.opc);
        end

        // Back-to-back: load presented in the retire cycle of the store, reads it back
        run_op(OPC_STORE, 3'b010, 32'h0000_0110, 32'h0BAD_F00D, 5'd0, 0, 1, o);
        chk("b2b_store_lat", 32'(o.lat), 32'd2);
        run_op(OPC_LOAD, 3'b010, 32'h0000_0110, 32'h0, 5'd20, 0, 1, o);
        chk("b2b_load_lat", 32'(o.lat), 32'd3);
        chk("b2b_load_result", o.res, 32'h0BAD_F00D);
        chk("b2b_load_rd", 32'(o.rd), 32'd20);

        // Reset while in REQ: request drops without waiting for a clock
        valid_in = 1'b1; opcode_in = OPC_STORE; funct3_in = 3'b010; result_in = 32'h0000_0114;
        data_in = 32'h1357_9BDF; rd_in = 5'd0;
        @(posedge clk); #1; valid_in = 1'b0;
        chk("req_before_rst", 32'(bus.mem_req), 32'd1);
        rst_n = 1'b0; #1;
        chk("rst_in_req_mem_req", 32'(bus.mem_req), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset while in WAIT, then a stale rvalid: nothing retires
        valid_in = 1'b1; opcode_in = OPC_LOAD; funct3_in = 3'b010; result_in = 32'h0000_0104; rd_in = 5'd7;
        @(posedge clk); #1; valid_in = 1'b0;
        bus.mem_gnt = 1'b1;
        @(posedge clk); #1; bus.mem_gnt = 1'b0;
        chk("wait_mem_req", 32'(bus.mem_req), 32'd0);
        chk("wait_stall", 32'(stall_out), 32'd1);
        rst_n = 1'b0; #1;
        chk("rst_in_wait_stall", 32'(stall_out), 32'd0);
        chk("rst_in_wait_result", result_out, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55AA_55AA;
        @(posedge clk); #1; bus.mem_rvalid = 1'b0;
        chk("stale_rvalid_no_retire", 32'(valid_out), 32'd0);
        chk("stale_rvalid_mem_req", 32'(bus.mem_req), 32'd0);
        @(posedge clk); #1;
        chk("stale_rvalid_no_retire2", 32'(valid_out), 32'd0);
        run_op(OPC_ALU, 3'b000, 32'hA5A5_0001, 32'h0, 5'd3, 0, 1, o);
        chk("post_rst_alu_lat", 32'(o.lat), 32'd1);
        chk("post_rst_alu_result", o.res, 32'hA5A5_0001);

`ifdef MEM_MISALIGN_TRAP_EN
        run_op(OPC_LOAD, 3'b010, 32'h0000_0102, 32'h0, 5'd9, 0, 1, o);
        chk("trap_lat", 32'(o.lat), 32'd1);
        chk("trap_req_seen", 32'(o.req_seen), 32'd0);
        chk("trap_misalign", 32'(o.mis), 32'd1);
        chk("trap_rd", 32'(o.rd), 32'd0);
        chk("trap_result", o.res, 32'h0000_0102);
`endif

        // Randomized ops against the byte-addressed reference memory
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 4; j++) ref_mem[4*i + j] = dut_mem[i][8*j +: 8];
        for (int n = 0; n < 80; n++) begin
            kind = int'($urandom_range(0, 2));
            d    = $urandom;
            rd   = 5'($urandom_range(0, 31));
            gd   = int'($urandom_range(0, 2));
            rv   = int'($urandom_range(1, 3));
            a    = 32'h100 + $urandom_range(0, 31);
            if (kind == 0) begin
                opc = OPC_ALU; f3 = 3'($urandom_range(0, 7)); a = $urandom;
            end else if (kind == 1) begin
                opc = OPC_STORE; f3 = 3'($urandom_range(0, 2));
            end else begin
                opc = OPC_LOAD;
                case ($urandom_range(0, 5))
                    0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
                    3: f3 = 3'b100; 4: f3 = 3'b101; default: f3 = 3'b011;
                endcase
            end
            is_mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            if (kind != 0) is_mis = (a % 32'(size_of(f3))) != 0;
`endif
            exp_rd = rd;
            if (kind == 0) begin
                exp_res = a; exp_lat = 1;
            end else if (is_mis) begin
                exp_res = a; exp_lat = 1; exp_rd = '0;
            end else if (kind == 1) begin
                exp_res = a; exp_lat = gd + 2;
                model_store(f3, a, d);
            end else begin
                exp_res = model_load(f3, a); exp_lat = gd + rv + 2;
            end
            run_op(opc, f3, a, d, rd, gd, rv, o);
            chk("rnd_lat", 32'(o.lat), 32'(exp_lat));
            chk("rnd_result", o.res, exp_res);
            chk("rnd_rd", 32'(o.rd), 32'(exp_rd));
            chk("rnd_opcode", 32'(o.opc), 32'(opc));
            chk("rnd_misalign", 32'(o.mis), 32'(is_mis));
            chk("rnd_req_seen", 32'(o.req_seen), 32'(kind != 0 && !is_mis));
            if (kind != 0 && !is_mis) begin
                chk("rnd_addr", o.addr, a - (a % 32'd4));
                chk("rnd_we", 32'(o.we), 32'(kind == 1));
                chk("rnd_stable", 32'(o.stable), 32'd1);
            end
            if ($urandom_range(0, 1) == 1) idle_check(exp_res, exp_rd, opc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
